// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths, defaults and arbiter state encoding for the regfile write-port arbiter.
package rf_wport_arbiter_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_STARVE = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_FORCE
  } arb_state_t;
endpackage

// File: rtl/rf_wport_arbiter_fifo.sv
// Secondary-writer queue: entries with live bits, WAW kill on core writes, per-entry read hits.
// Push/pop take effect at the clock edge; the head is visible combinationally.
module rf_wq_fifo
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [AW-1:0]    push_addr,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  input  logic             kill,
  input  logic [AW-1:0]    kill_addr,
  input  logic [AW-1:0]    raddr1,
  input  logic [AW-1:0]    raddr2,
  output logic             head_live,
  output logic [AW-1:0]    head_addr,
  output logic [DW-1:0]    head_data,
  output logic [CW-1:0]    count,
  output logic [DEPTH-1:0] hit1,
  output logic [DEPTH-1:0] hit2
);
  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] live_q;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  // Live is cleared on pop so that live alone marks an occupied, still-valid entry.
  // The push assignment comes last: a same-cycle younger write to the killed address stays live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live_q  <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill && live_q[i] && addr_q[i] == kill_addr) live_q[i] <= 1'b0;
      end
      if (pop) begin
        live_q[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + PW'(1);
      end
      if (push) begin
        live_q[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    hit1 = '0;
    hit2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = live_q[i] && (addr_q[i] == raddr1);
      hit2[i] = live_q[i] && (addr_q[i] == raddr2);
    end
  end

  assign head_live = live_q[rd_ptr];
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];
  assign count     = count_q;
endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port: core writeback wins with zero latency, queued secondary writes
// fill idle cycles, and a starved queue head steals one cycle by stalling the core.
module rf_wport_arbiter
  import rf_wport_arbiter_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int STARVE = DEF_STARVE,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int SW = $clog2(STARVE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_we,
  input  logic [AW-1:0] a_waddr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_stall,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_waddr,
  input  logic [DW-1:0] b_wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic          rd1_pending,
  output logic          rd2_pending,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [CW-1:0] pending_cnt
);
  arb_state_t       state;
  logic [SW-1:0]    starve_q, starve_d;
  logic             push, pop, kill, a_req;
  logic             head_live;
  logic [AW-1:0]    head_addr;
  logic [DW-1:0]    head_data;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] hit1, hit2;

  rf_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (b_waddr),
    .push_data (b_wdata),
    .pop       (pop),
    .kill      (kill),
    .kill_addr (a_waddr),
    .raddr1    (raddr1),
    .raddr2    (raddr2),
    .head_live (head_live),
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (count),
    .hit1      (hit1),
    .hit2      (hit2)
  );

  assign b_ready     = count < CW'(DEPTH);
  assign push        = b_valid && b_ready && (b_waddr != REG_ZERO);
  assign pending_cnt = count;
  assign rd1_pending = (raddr1 != REG_ZERO) && (|hit1);
  assign rd2_pending = (raddr2 != REG_ZERO) && (|hit2);
  assign a_req       = a_we && (a_waddr != REG_ZERO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  always_comb begin
    if (count == '0)                  state = ST_IDLE;
    else if (starve_q == SW'(STARVE)) state = ST_FORCE;
    else                              state = ST_DRAIN;
    starve_d = starve_q;
    if (pop || state == ST_IDLE)      starve_d = '0;
    else if (starve_q != SW'(STARVE)) starve_d = starve_q + SW'(1);
  end

  // Outputs are gated by reset so nothing reaches the regfile while it is held.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = head_addr;
    rf_wdata = head_data;
    a_stall  = 1'b0;
    pop      = 1'b0;
    kill     = 1'b0;
    if (state == ST_FORCE) begin
      a_stall = 1'b1;
      pop     = 1'b1;
      rf_we   = head_live;
    end else if (a_req) begin
      rf_we    = 1'b1;
      rf_waddr = a_waddr;
      rf_wdata = a_wdata;
      kill     = 1'b1;
    end else if (state == ST_DRAIN) begin
      pop   = 1'b1;
      rf_we = head_live;
    end
    if (!rst) begin
      rf_we   = 1'b0;
      a_stall = 1'b0;
      pop     = 1'b0;
      kill    = 1'b0;
    end
  end
endmodule
